// File: rtl/bus_txn_arbiter.sv
// bus_txn_arbiter: two-master arbiter for the Rx Engine register bus.
// Sequences each grant into registered address, strobe and ack signals.
module bus_txn_arbiter #(
  parameter int unsigned DW        = 16,
  parameter int unsigned WAIT_CYC  = 1,
  parameter bit          FIXED_PRI = 1'b0
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          REQ0,
  input  logic          RNW0,
  input  logic [4:0]    ADDR0,
  input  logic [DW-1:0] WDAT0,
  output logic          ACK0,
  input  logic          REQ1,
  input  logic          RNW1,
  input  logic [4:0]    ADDR1,
  input  logic [DW-1:0] WDAT1,
  output logic          ACK1,
  output logic [DW-1:0] RDAT,
  input  logic [DW-1:0] BUS_DIN,
  output logic [DW-1:0] BUS_DOUT,
  output logic [1:0]    ADHI,
  output logic [2:0]    ADIO,
  output logic          READ,
  output logic          WRITE,
  output logic          BUSY
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    STRB = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LD = 4'(WAIT_CYC - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       last;
  logic       win;
  logic       rnw_q;
  logic       gnt1;

  // Tie goes to the master that did not win last, unless M0 is fixed-priority
  always_comb begin
    gnt1 = REQ1 & (~REQ0 | (~FIXED_PRI & ~last));
  end

  // Transaction sequencer with all bus-facing outputs registered
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      cnt      <= '0;
      last     <= 1'b1;
      win      <= 1'b0;
      rnw_q    <= 1'b0;
      ADHI     <= '0;
      ADIO     <= '0;
      BUS_DOUT <= '0;
      RDAT     <= '0;
      READ     <= 1'b0;
      WRITE    <= 1'b0;
      ACK0     <= 1'b0;
      ACK1     <= 1'b0;
      BUSY     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (REQ0 | REQ1) begin
            win      <= gnt1;
            last     <= gnt1;
            rnw_q    <= gnt1 ? RNW1 : RNW0;
            ADHI     <= gnt1 ? ADDR1[4:3] : ADDR0[4:3];
            ADIO     <= gnt1 ? ADDR1[2:0] : ADDR0[2:0];
            BUS_DOUT <= gnt1 ? WDAT1 : WDAT0;
            BUSY     <= 1'b1;
            state    <= ADDR;
          end
        end
        ADDR: begin
          READ  <= rnw_q;
          WRITE <= ~rnw_q;
          cnt   <= CNT_LD;
          state <= STRB;
        end
        STRB: begin
          if (cnt == 4'd0) begin
            READ  <= 1'b0;
            WRITE <= 1'b0;
            if (rnw_q) RDAT <= BUS_DIN;
            ACK0  <= ~win;
            ACK1  <= win;
            state <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          ACK0  <= 1'b0;
          ACK1  <= 1'b0;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_txn_arbiter.sv
// tb_bus_txn_arbiter: directed checks of grant order, timing and reset.
// Instance 0: WAIT_CYC=1 round-robin; instance 1: WAIT_CYC=3 fixed priority.
module tb_bus_txn_arbiter;

  logic        CLK;
  logic        RST_N;
  logic        REQ0, RNW0, REQ1, RNW1;
  logic [4:0]  ADDR0, ADDR1;
  logic [15:0] WDAT0, WDAT1, BUS_DIN;

  logic        ack0 [2];
  logic        ack1 [2];
  logic [15:0] rdat [2];
  logic [15:0] dout [2];
  logic [1:0]  adhi [2];
  logic [2:0]  adio [2];
  logic        rd   [2];
  logic        wr   [2];
  logic        busy [2];
  logic        prev0 [2];
  logic        prev1 [2];

  int total = 0;
  int bad   = 0;
  int w;

  bus_txn_arbiter #(.DW(16), .WAIT_CYC(1), .FIXED_PRI(1'b0)) u_rr (
    .CLK(CLK), .RST_N(RST_N),
    .REQ0(REQ0), .RNW0(RNW0), .ADDR0(ADDR0), .WDAT0(WDAT0), .ACK0(ack0[0]),
    .REQ1(REQ1), .RNW1(RNW1), .ADDR1(ADDR1), .WDAT1(WDAT1), .ACK1(ack1[0]),
    .RDAT(rdat[0]), .BUS_DIN(BUS_DIN), .BUS_DOUT(dout[0]),
    .ADHI(adhi[0]), .ADIO(adio[0]), .READ(rd[0]), .WRITE(wr[0]),
    .BUSY(busy[0])
  );

  bus_txn_arbiter #(.DW(16), .WAIT_CYC(3), .FIXED_PRI(1'b1)) u_fp (
    .CLK(CLK), .RST_N(RST_N),
    .REQ0(REQ0), .RNW0(RNW0), .ADDR0(ADDR0), .WDAT0(WDAT0), .ACK0(ack0[1]),
    .REQ1(REQ1), .RNW1(RNW1), .ADDR1(ADDR1), .WDAT1(WDAT1), .ACK1(ack1[1]),
    .RDAT(rdat[1]), .BUS_DIN(BUS_DIN), .BUS_DOUT(dout[1]),
    .ADHI(adhi[1]), .ADIO(adio[1]), .READ(rd[1]), .WRITE(wr[1]),
    .BUSY(busy[1])
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    REQ0  = 1'b0;
    REQ1  = 1'b0;
    tick();
    tick();
    RST_N = 1'b1;
  endtask

  // Returns 0/1 for the acked master, 2 if no ack within the budget
  task automatic wait_ack(input int s, output int who);
    bit seen;
    seen = 1'b0;
    who  = 2;
    for (int i = 0; i < 20; i++) begin
      if (!seen) begin
        tick();
        if (ack0[s] | ack1[s]) begin
          who  = ack1[s] ? 1 : 0;
          seen = 1'b1;
        end
      end
    end
    if (!seen) chk("ack_timeout", 1, 0);
  endtask

  always @(negedge CLK) begin
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("rw_excl%0d", s), rd[s] & wr[s], 0);
      chk($sformatf("ack_excl%0d", s), ack0[s] & ack1[s], 0);
      chk($sformatf("ack0_width%0d", s), ack0[s] & prev0[s], 0);
      chk($sformatf("ack1_width%0d", s), ack1[s] & prev1[s], 0);
      prev0[s] <= ack0[s];
      prev1[s] <= ack1[s];
    end
  end

  initial begin
    prev0[0] = 0; prev0[1] = 0; prev1[0] = 0; prev1[1] = 0;
    RST_N   = 1'b0;
    REQ0    = 1'b1;
    REQ1    = 1'b1;
    RNW0    = 1'b1;
    RNW1    = 1'b1;
    ADDR0   = 5'b00_001;
    ADDR1   = 5'b11_110;
    WDAT0   = 16'h1111;
    WDAT1   = 16'h2222;
    BUS_DIN = 16'h0000;

    // T1 reset with both requests pending
    tick();
    tick();
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("rst_busy%0d", s), busy[s], 0);
      chk($sformatf("rst_strb%0d", s), {rd[s], wr[s]}, 0);
      chk($sformatf("rst_ack%0d", s), {ack0[s], ack1[s]}, 0);
      chk($sformatf("rst_rdat%0d", s), rdat[s], 0);
      chk($sformatf("rst_addr%0d", s), {adhi[s], adio[s]}, 0);
      chk($sformatf("rst_dout%0d", s), dout[s], 0);
    end
    RST_N = 1'b1;
    tick();
    chk("t1_first_rr", {adhi[0], adio[0]}, 5'b00_001);
    chk("t1_first_fp", {adhi[1], adio[1]}, 5'b00_001);
    chk("t1_busy", busy[0], 1);

    // T2 M0 write on the WAIT_CYC=1 instance
    do_reset();
    REQ0  = 1'b1;
    RNW0  = 1'b0;
    ADDR0 = 5'b10_011;
    WDAT0 = 16'hA5A5;
    tick();
    chk("t2_c1_addr", {adhi[0], adio[0]}, 5'b10_011);
    chk("t2_c1_dout", dout[0], 16'hA5A5);
    chk("t2_c1_strb", {rd[0], wr[0]}, 2'b00);
    tick();
    chk("t2_c2_strb", {rd[0], wr[0]}, 2'b01);
    chk("t2_c2_ack", ack0[0], 0);
    tick();
    chk("t2_c3_strb", {rd[0], wr[0]}, 2'b00);
    chk("t2_c3_ack", {ack0[0], ack1[0]}, 2'b10);
    REQ0 = 1'b0;
    tick();
    chk("t2_c4_ack", ack0[0], 0);
    chk("t2_c4_busy", busy[0], 0);
    chk("t2_c4_hold", {adhi[0], adio[0]}, 5'b10_011);

    // T3 M1 read on the WAIT_CYC=3 instance
    do_reset();
    REQ1    = 1'b1;
    RNW1    = 1'b1;
    ADDR1   = 5'b01_111;
    BUS_DIN = 16'h0000;
    tick();
    chk("t3_c1_addr", {adhi[1], adio[1]}, 5'b01_111);
    chk("t3_c1_read", rd[1], 0);
    tick();
    chk("t3_c2_read", {rd[1], wr[1]}, 2'b10);
    tick();
    chk("t3_c3_read", rd[1], 1);
    tick();
    chk("t3_c4_read", rd[1], 1);
    chk("t3_c4_ack", ack1[1], 0);
    BUS_DIN = 16'h1234;
    tick();
    chk("t3_c5_read", rd[1], 0);
    chk("t3_c5_ack", {ack0[1], ack1[1]}, 2'b01);
    chk("t3_c5_rdat", rdat[1], 16'h1234);
    REQ1 = 1'b0;
    BUS_DIN = 16'h0000;
    tick();
    chk("t3_c6_ack", ack1[1], 0);
    chk("t3_c6_busy", busy[1], 0);
    chk("t3_c6_rdat_hold", rdat[1], 16'h1234);

    // T5b reset pulse during STRB of a read (RDAT currently 1234)
    REQ1    = 1'b1;
    BUS_DIN = 16'hBEEF;
    tick();
    tick();
    chk("t5b_strb", rd[1], 1);
    #3;
    RST_N = 1'b0;
    #1;
    chk("t5b_read_drop", rd[1], 0);
    chk("t5b_busy", busy[1], 0);
    chk("t5b_rdat_clr", rdat[1], 0);
    REQ1 = 1'b0;
    tick();
    RST_N = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5b_no_ack", {ack0[1], ack1[1]}, 0);
      chk("t5b_idle", busy[1], 0);
    end

    // T4 round-robin with both requests held
    do_reset();
    RNW0  = 1'b1;
    RNW1  = 1'b0;
    REQ0  = 1'b1;
    REQ1  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_ack(0, w);
      chk($sformatf("t4_rr_grant%0d", k), w, k % 2);
    end

    // T4 fixed priority: M0 until it drops
    do_reset();
    REQ0 = 1'b1;
    REQ1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_ack(1, w);
      chk($sformatf("t4_fp_grant%0d", k), w, 0);
    end
    REQ0 = 1'b0;
    wait_ack(1, w);
    chk("t4_fp_after_drop", w, 1);
    REQ1 = 1'b0;

    // T5a M0 drops REQ during STRB; access still completes
    do_reset();
    REQ0  = 1'b1;
    RNW0  = 1'b0;
    ADDR0 = 5'b01_010;
    WDAT0 = 16'h5A5A;
    tick();
    tick();
    chk("t5a_write", wr[0], 1);
    REQ0 = 1'b0;
    tick();
    chk("t5a_ack", {ack0[0], ack1[0]}, 2'b10);
    tick();
    chk("t5a_ack_end", ack0[0], 0);
    tick();
    chk("t5a_stay_idle", busy[0], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
